// File: rtl/fix_point_accumulator.sv
// fix_point_accumulator
//   Initiator side of the fixed-point adder poke/peek handshake. Accepts LEN
//   sign-magnitude samples on a valid/ready input and, for each one, pokes an
//   external adder with {running accumulator, sample}. It captures the
//   adder's result as the new accumulator. The final sum is presented on
//   acc_out with a one-cycle acc_valid pulse.
//
// Optional build macro: FXACC_OVF_DETECT_EN
//   When defined, a same-sign add whose result magnitude shrinks is
//   saturated to {sign, all ones} and the sticky ovf flag is set. When
//   undefined, the adder result is stored as-is and ovf is tied low.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   start, len           begin an accumulation of len samples (IDLE only)
//   in_data/in_valid/in_ready   sample input handshake
//   add_a, add_b         adder operands (accumulator, latched sample)
//   add_poke             one-cycle adder request
//   add_sum, add_peek    adder result and result-valid
//   acc_out, acc_valid   final sum and its one-cycle valid pulse
//   busy                 high whenever not IDLE
//   err                  sticky adder timeout flag, cleared by accepted start
//   ovf                  sticky magnitude overflow flag
`default_nettype none

module fix_point_accumulator #(
  parameter int N       = 16,
  parameter int Q       = 13,
  parameter int CNT_W   = 8,
  parameter int ADD_LAT = 1,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  output logic             add_poke,
  input  logic [N-1:0]     add_sum,
  input  logic             add_peek,
  output logic [N-1:0]     acc_out,
  output logic             acc_valid,
  output logic             busy,
  output logic             err,
  output logic             ovf
);

  if (Q >= N || TIMEOUT <= ADD_LAT) begin : g_param_check
    $error("fix_point_accumulator: need Q < N and TIMEOUT > ADD_LAT");
  end

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] LAT_C    = ADD_LAT[WCNT_W-1:0];
  localparam logic [WCNT_W-1:0] TO_C     = TIMEOUT[WCNT_W-1:0];
  localparam logic [WCNT_W-1:0] W_ONE    = {{(WCNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]      NEG_ZERO = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_POKE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [N-1:0]      r_acc;
  logic [N-1:0]      r_opb;
  logic [CNT_W-1:0]  r_cnt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [N-1:0]      r_acc_out;
  logic              r_acc_valid;
  logic              r_err;

  logic              w_accept;
  logic              w_capture;
  logic              w_timeout;
  logic [WCNT_W-1:0] w_wcnt_inc;
  logic [N-1:0]      w_capt;
  logic [N-1:0]      w_capt_norm;

  // The wait counter is cleared in POKE; w_wcnt_inc is the number of cycles
  // elapsed since the poke cycle, so the first WAIT cycle already counts as
  // one. This gives the LOAD/POKE/WAIT three-cycle rate with ADD_LAT=1.
  assign w_wcnt_inc = r_wcnt + W_ONE;

`ifdef FXACC_OVF_DETECT_EN
  logic r_ovf;
  logic w_ovf;

  // Same-sign add whose magnitude came back smaller than an operand wrapped.
  assign w_ovf  = (r_acc[N-1] == r_opb[N-1]) &&
                  ((add_sum[N-2:0] < r_acc[N-2:0]) ||
                   (add_sum[N-2:0] < r_opb[N-2:0]));
  assign w_capt = w_ovf ? {r_acc[N-1], {(N-1){1'b1}}} : add_sum;
  assign ovf    = r_ovf;
`else
  assign w_capt = add_sum;
  assign ovf    = 1'b0;
`endif

  assign w_capt_norm = (w_capt == NEG_ZERO) ? '0 : w_capt;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: if (start && (len != '0)) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_POKE;
        end
      end
      S_POKE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if ((w_wcnt_inc >= LAT_C) && add_peek) begin
          w_capture   = 1'b1;
          w_state_nxt = (r_cnt == CNT_ONE) ? S_DONE : S_LOAD;
        end else if (w_wcnt_inc >= TO_C) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // acc_out/acc_valid are loaded on the edge entering DONE, so the pulse
  // coincides with the DONE cycle and acc_out is already valid during it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_opb       <= '0;
      r_cnt       <= '0;
      r_wcnt      <= '0;
      r_acc_out   <= '0;
      r_acc_valid <= 1'b0;
      r_err       <= 1'b0;
`ifdef FXACC_OVF_DETECT_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_acc_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              r_acc <= '0;
              r_cnt <= len;
              r_err <= 1'b0;
`ifdef FXACC_OVF_DETECT_EN
              r_ovf <= 1'b0;
`endif
            end else begin
              r_acc_out   <= '0;
              r_acc_valid <= 1'b1;
            end
          end
        end
        S_LOAD: if (w_accept) r_opb <= in_data;
        S_POKE: r_wcnt <= '0;
        S_WAIT: begin
          r_wcnt <= w_wcnt_inc;
          if (w_capture) begin
            r_acc <= w_capt_norm;
            r_cnt <= r_cnt - CNT_ONE;
`ifdef FXACC_OVF_DETECT_EN
            if (w_ovf) r_ovf <= 1'b1;
`endif
            if (r_cnt == CNT_ONE) begin
              r_acc_out   <= w_capt_norm;
              r_acc_valid <= 1'b1;
            end
          end
          if (w_timeout) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign add_poke  = (r_state == S_POKE);
  assign add_a     = r_acc;
  assign add_b     = r_opb;
  assign acc_out   = r_acc_out;
  assign acc_valid = r_acc_valid;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fix_point_accumulator.sv
// Directed bench for fix_point_accumulator with a behavioural one-cycle
// sign-magnitude adder and a scoreboard of expected final sums.
module tb_fix_point_accumulator;

  logic        clk = 1'b0;
  logic        rstn, start, in_valid, in_ready, add_poke, add_peek;
  logic        acc_valid, busy, err, ovf;
  logic [7:0]  len;
  logic [15:0] in_data, add_a, add_b, add_sum, acc_out;

  int n_assert = 0;
  int n_fail   = 0;
  int poke_cnt = 0;
  int valid_cnt = 0;
  int ready_cnt = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  fix_point_accumulator #(
    .N(16), .Q(13), .CNT_W(8), .ADD_LAT(1), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_poke(add_poke),
    .add_sum(add_sum), .add_peek(add_peek),
    .acc_out(acc_out), .acc_valid(acc_valid),
    .busy(busy), .err(err), .ovf(ovf)
  );

  // Behavioural sign-magnitude adder; result and peek one cycle after poke.
  logic        adder_en = 1'b1;
  logic        r_peek = 1'b0;
  logic [15:0] r_sum = 16'h0000;

  function automatic logic [15:0] sm_add(input logic [15:0] a, input logic [15:0] b);
    logic [14:0] ma, mb;
    ma = a[14:0];
    mb = b[14:0];
    if (a[15] == b[15]) return {a[15], 15'(ma + mb)};
    else if (ma > mb)   return {a[15], 15'(ma - mb)};
    else                return {b[15], 15'(mb - ma)};
  endfunction

  always @(posedge clk) begin
    if (add_poke) r_sum <= sm_add(add_a, add_b);
    r_peek <= add_poke;
  end
  assign add_sum  = r_sum;
  assign add_peek = r_peek & adder_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every acc_valid pulse.
  always @(negedge clk) begin
    if (add_poke) poke_cnt++;
    if (in_ready) ready_cnt++;
    if (acc_valid) begin
      valid_cnt++;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("acc_out", 32'(acc_out), 32'(sb.pop_front()));
    end
  end

  task automatic do_start(input logic [7:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] d);
    int k;
    k = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_timeout", 32'(k < 50), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int base);
    int k;
    k = 0;
    while (valid_cnt == base && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("acc_valid_timeout", 32'(k < 200), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int p0, v0, r0, k;
    logic [15:0] exp_ovf_sum;
    logic        exp_ovf;

    rstn = 1'b0; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({in_ready, add_poke, acc_valid, busy, err, ovf}), 32'd0);
    chk("reset_acc_out", 32'(acc_out), 32'd0);
    chk("reset_operands", 32'({add_a, add_b}), 32'd0);
    rstn = 1'b1;

    // 0.5 + 0.25 + (-1.0) = -0.25
    p0 = poke_cnt; v0 = valid_cnt;
    sb.push_back(16'h8800);
    do_start(8'd3);
    feed(16'h1000); feed(16'h0800); feed(16'hA000);
    wait_valid(v0);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_pokes", 32'(poke_cnt - p0), 32'd3);
    repeat (3) @(negedge clk);
    chk("t1_single_pulse", 32'(valid_cnt - v0), 32'd1);

    // adder returns negative zero, stored as +0
    v0 = valid_cnt;
    sb.push_back(16'h0000);
    do_start(8'd2);
    feed(16'h2000); feed(16'hA000);
    wait_valid(v0);

    // adder never answers: timeout after 8 WAIT cycles
    adder_en = 1'b0;
    v0 = valid_cnt;
    do_start(8'd1);
    feed(16'h0055);
    @(negedge clk);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (err) break;
      k++;
    end
    chk("timeout_wait_cycles", 32'(k), 32'd8);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_idle", 32'(busy), 32'd0);
    chk("timeout_no_valid", 32'(valid_cnt - v0), 32'd0);
    adder_en = 1'b1;
    sb.push_back(16'h0400);
    do_start(8'd1);
    chk("err_cleared", 32'(err), 32'd0);
    feed(16'h0400);
    wait_valid(v0);

    // magnitude overflow
`ifdef FXACC_OVF_DETECT_EN
    exp_ovf_sum = 16'h7FFF; exp_ovf = 1'b1;
`else
    exp_ovf_sum = 16'h1000; exp_ovf = 1'b0;
`endif
    v0 = valid_cnt;
    sb.push_back(exp_ovf_sum);
    do_start(8'd2);
    feed(16'h7000); feed(16'h2000);
    wait_valid(v0);
    chk("ovf_flag", 32'(ovf), 32'(exp_ovf));

    // len = 0: immediate zero result, no data accepted
    v0 = valid_cnt; r0 = ready_cnt;
    sb.push_back(16'h0000);
    do_start(8'd0);
    wait_valid(v0);
    chk("len0_no_ready", 32'(ready_cnt - r0), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);

    // start while busy is ignored
    v0 = valid_cnt; p0 = poke_cnt;
    sb.push_back(16'h0300);
    do_start(8'd2);
    feed(16'h0100);
    start = 1'b1; len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    feed(16'h0200);
    wait_valid(v0);
    repeat (3) @(negedge clk);
    chk("busy_start_pulses", 32'(valid_cnt - v0), 32'd1);
    chk("busy_start_pokes", 32'(poke_cnt - p0), 32'd2);

    // reset during WAIT of the second sample
    v0 = valid_cnt;
    do_start(8'd3);
    feed(16'h0100); feed(16'h0200);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", 32'({in_ready, add_poke, acc_valid, busy, err, ovf}), 32'd0);
    chk("abort_acc_out", 32'(acc_out), 32'd0);
    chk("abort_operands", 32'({add_a, add_b}), 32'd0);
    chk("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    rstn = 1'b1;
    sb.push_back(16'h0123);
    do_start(8'd1);
    feed(16'h0123);
    wait_valid(v0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
